// File: rtl/s_machine_alu_pkg.sv
// Shared opcodes, FSM states and decode helpers for the
// sequential S-Machine ALU.
package s_machine_alu_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_SHL1 = 4'h8;
    localparam logic [3:0] OP_SHR1 = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_SHRV = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    function automatic logic op_known(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHRV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the register-read
// stage, the ALU and write-back.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      inst;
    logic [WIDTH-1:0] register_A_in;
    logic [WIDTH-1:0] register_B_in;
    logic             Z_in;
    logic             N_in;
    logic             C_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] register_A_out;
    logic [WIDTH-1:0] register_B_out;
    logic             Z_out;
    logic             N_out;
    logic             C_out;
    logic             busy;

    modport master (
        output in_valid, inst, register_A_in, register_B_in,
        output Z_in, N_in, C_in, out_ready,
        input  in_ready, out_valid, register_A_out, register_B_out,
        input  Z_out, N_out, C_out, busy
    );

    modport slave (
        input  in_valid, inst, register_A_in, register_B_in,
        input  Z_in, N_in, C_in, out_ready,
        output in_ready, out_valid, register_A_out, register_B_out,
        output Z_out, N_out, C_out, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle,
// WIDTH iterations after start; product holds until next start.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic             run;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   sum;

    // low half starts as the multiplier and drains out as the product fills in
    assign sum = {1'b0, product[2*WIDTH-1:WIDTH]}
               + (product[0] ? {1'b0, mcand} : '0);
    assign last = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            mcand   <= '0;
            cnt     <= '0;
            run     <= 1'b0;
        end else if (start) begin
            product <= {{WIDTH{1'b0}}, b};
            mcand   <= a;
            cnt     <= '0;
            run     <= 1'b1;
        end else if (run) begin
            product <= {sum, product[WIDTH-1:1]};
            cnt     <= cnt + CW'(1);
            if (last) run <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU between register read and write-back: single-cycle
// ops plus iterative MUL and variable right shift.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    import s_machine_alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [3:0]       opc, op_q;
    logic [WIDTH-1:0] res_a, b_q, a_res;
    logic             res_c, z_q, n_q;
    logic [SHW-1:0]   cnt, shamt;
    logic             accept, mul_start, mul_last, is_mul;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   add_sum, sub_dif;
    logic             unused_inst;

    assign opc         = bus.inst[OPC_MSB:OPC_LSB];
    assign unused_inst = ^bus.inst[OPC_LSB-1:0];
    assign shamt       = bus.register_B_in[SHW-1:0];
    assign accept      = bus.in_valid && (state == IDLE);
    assign mul_start   = accept && (opc == OP_MUL);
    assign is_mul      = (op_q == OP_MUL);
    assign add_sum = {1'b0, bus.register_A_in} + {1'b0, bus.register_B_in};
    assign sub_dif = {1'b0, bus.register_A_in} - {1'b0, bus.register_B_in};

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.register_A_in),
        .b       (bus.register_B_in),
        .last    (mul_last),
        .product (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.in_valid) begin
                if (opc == OP_MUL || (opc == OP_SHRV && shamt != '0))
                    state_n = EXEC;
                else
                    state_n = DONE;
            end
            EXEC: if (is_mul ? mul_last : (cnt == SHW'(1)))
                state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            b_q   <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            cnt   <= '0;
            res_a <= '0;
            res_c <= 1'b0;
        end else if (accept) begin
            op_q  <= opc;
            b_q   <= bus.register_B_in;
            z_q   <= bus.Z_in;
            n_q   <= bus.N_in;
            cnt   <= shamt;
            res_a <= bus.register_A_in;
            res_c <= bus.C_in;
            unique case (opc)
                OP_ADD: begin
                    res_a <= add_sum[WIDTH-1:0];
                    res_c <= add_sum[WIDTH];
                end
                OP_SUB: begin
                    res_a <= sub_dif[WIDTH-1:0];
                    res_c <= sub_dif[WIDTH];
                end
                OP_AND: res_a <= bus.register_A_in & bus.register_B_in;
                OP_OR:  res_a <= bus.register_A_in | bus.register_B_in;
                OP_SHL1: begin
                    res_a <= {bus.register_A_in[WIDTH-2:0], 1'b0};
                    res_c <= bus.register_A_in[WIDTH-1];
                end
                OP_SHR1: begin
                    res_a <= {1'b0, bus.register_A_in[WIDTH-1:1]};
                    res_c <= bus.register_A_in[0];
                end
                default: ;
            endcase
        end else if (state == EXEC && op_q == OP_SHRV) begin
            res_a <= {1'b0, res_a[WIDTH-1:1]};
            res_c <= res_a[0];
            cnt   <= cnt - SHW'(1);
        end
    end

    // results are only driven in DONE so reset zeroes them immediately
    always_comb begin
        a_res              = is_mul ? prod[WIDTH-1:0] : res_a;
        bus.in_ready       = (state == IDLE);
        bus.busy           = (state != IDLE);
        bus.out_valid      = (state == DONE);
        bus.register_A_out = '0;
        bus.register_B_out = '0;
        bus.Z_out          = 1'b0;
        bus.N_out          = 1'b0;
        bus.C_out          = 1'b0;
        if (state == DONE) begin
            bus.register_A_out = a_res;
            bus.register_B_out = is_mul ? prod[2*WIDTH-1:WIDTH] : b_q;
            bus.C_out = is_mul ? |prod[2*WIDTH-1:WIDTH] : res_c;
            bus.Z_out = op_known(op_q) ? (a_res == '0) : z_q;
            bus.N_out = op_known(op_q) ? a_res[WIDTH-1] : n_q;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus model-driven bench for alu_seq with a queue
// scoreboard of expected results.
module tb_alu_seq;
    localparam int W = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        z;
        logic        n;
        logic        c;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic z, input logic n,
                                input logic c, input int lat);
        exp_t e;
        e.a = a; e.b = b; e.z = z; e.n = n; e.c = c; e.lat = lat;
        return e;
    endfunction

    // independent reference for the random phase
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic z,
                                   input logic n, input logic c);
        exp_t e;
        logic [16:0] s;
        logic [31:0] p;
        int sh;
        e.a = a; e.b = b; e.c = c; e.lat = 1;
        case (op)
            4'h4: begin
                s = {1'b0, a} + {1'b0, b};
                e.a = s[15:0]; e.c = s[16];
            end
            4'h5: begin e.a = a - b; e.c = (a < b); end
            4'h6: e.a = a & b;
            4'h7: e.a = a | b;
            4'h8: begin e.a = a << 1; e.c = a[15]; end
            4'h9: begin e.a = a >> 1; e.c = a[0]; end
            4'hA: begin
                p = a * b;
                e.a = p[15:0]; e.b = p[31:16];
                e.c = |p[31:16]; e.lat = 17;
            end
            4'hB: begin
                sh = int'(b[3:0]);
                if (sh != 0) begin
                    e.a = a >> sh; e.c = a[sh-1]; e.lat = sh + 1;
                end
            end
            default: ;
        endcase
        if (op >= 4'h4 && op <= 4'hB) begin
            e.z = (e.a == 16'h0); e.n = e.a[15];
        end else begin
            e.z = z; e.n = n;
        end
        return e;
    endfunction

    task automatic send(input logic [15:0] inst, input logic [15:0] a,
                        input logic [15:0] b, input logic z, input logic n,
                        input logic c, input exp_t e);
        @(negedge clk);
        bus.inst = inst;
        bus.register_A_in = a;
        bus.register_B_in = b;
        bus.Z_in = z; bus.N_in = n; bus.C_in = c;
        bus.in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.inst = 16'($urandom);
        bus.register_A_in = 16'($urandom);
        bus.register_B_in = 16'($urandom);
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic compare(input string tag, input int lat);
        exp_t e;
        chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_a"}, 32'(bus.register_A_out), 32'(e.a));
        chk({tag, "_b"}, 32'(bus.register_B_out), 32'(e.b));
        chk({tag, "_znc"}, 32'({bus.Z_out, bus.N_out, bus.C_out}),
            32'({e.z, e.n, e.c}));
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'({bus.in_ready, bus.busy}), 32'b10);
    endtask

    task automatic run_op(input string tag, input logic [15:0] inst,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic z, input logic n, input logic c,
                          input exp_t e);
        int lat;
        send(inst, a, b, z, n, c, e);
        wait_out(tag, lat);
        compare(tag, lat);
        take(tag);
    endtask

    initial begin
        int lat;
        exp_t e;
        logic [3:0] op;
        logic [15:0] ra, rb;
        logic [2:0] fl;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.inst = '0;
        bus.register_A_in = '0;
        bus.register_B_in = '0;
        bus.Z_in = 1'b0; bus.N_in = 1'b0; bus.C_in = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_outs", 32'({bus.out_valid, bus.busy, bus.register_A_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_outs", 32'({bus.out_valid, bus.busy, bus.register_A_out,
            bus.Z_out, bus.N_out, bus.C_out}), 32'd0);

        run_op("add", 16'h4000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0,
               mk(16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, 1));
        run_op("sub_eq", 16'h5000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0,
               mk(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1));
        run_op("sub_brw", 16'h5000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0,
               mk(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, 1));
        run_op("add_cy", 16'h4ABC, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0,
               mk(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 1));
        run_op("and", 16'h6000, 16'hF0F0, 16'h8F00, 1'b0, 1'b0, 1'b1,
               mk(16'h8000, 16'h8F00, 1'b0, 1'b1, 1'b1, 1));
        run_op("or", 16'h7000, 16'h0F00, 16'h00F0, 1'b1, 1'b1, 1'b0,
               mk(16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1));
        run_op("shl1", 16'h8000, 16'h8000, 16'h1234, 1'b0, 1'b0, 1'b0,
               mk(16'h0000, 16'h1234, 1'b1, 1'b0, 1'b1, 1));
        run_op("shr1", 16'h9000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1,
               mk(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1));
        run_op("mul", 16'hA000, 16'h1234, 16'h0100, 1'b0, 1'b0, 1'b0,
               mk(16'h3400, 16'h0012, 1'b0, 1'b0, 1'b1, 17));
        run_op("mul_max", 16'hA000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0,
               mk(16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b1, 17));
        run_op("shrv3", 16'hB000, 16'h8001, 16'h0003, 1'b0, 1'b0, 1'b1,
               mk(16'h1000, 16'h0003, 1'b0, 1'b0, 1'b0, 4));
        run_op("shrv0", 16'hB000, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1,
               mk(16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1));
        run_op("shrv15", 16'hB000, 16'hFFFF, 16'h00FF, 1'b0, 1'b0, 1'b0,
               mk(16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b1, 16));
        run_op("unk", 16'h0123, 16'h0000, 16'h0005, 1'b0, 1'b1, 1'b1,
               mk(16'h0000, 16'h0005, 1'b0, 1'b1, 1'b1, 1));
        run_op("unk_f", 16'hF000, 16'h8001, 16'h0007, 1'b1, 1'b0, 1'b0,
               mk(16'h8001, 16'h0007, 1'b1, 1'b0, 1'b0, 1));

        // backpressure: result must hold and new requests be ignored
        send(16'h4000, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0,
             mk(16'h0007, 16'h0004, 1'b0, 1'b0, 1'b0, 1));
        wait_out("bp", lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.inst = 16'h5000;
            bus.register_A_in = 16'($urandom);
            @(posedge clk);
            #1;
            chk("bp_hold", 32'({bus.out_valid, bus.in_ready,
                bus.register_A_out}), 32'({1'b1, 1'b0, 16'h0007}));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        compare("bp", lat);
        take("bp");
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_ghost", 32'({bus.out_valid, bus.busy}), 32'd0);

        // asynchronous reset in the middle of a multiply
        send(16'hA000, 16'h1234, 16'h0100, 1'b0, 1'b0, 1'b0,
             mk(16'h3400, 16'h0012, 1'b0, 1'b0, 1'b1, 17));
        repeat (7) @(posedge clk);
        #1;
        chk("mid_mul_busy", 32'({bus.busy, bus.out_valid}), 32'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", 32'({bus.out_valid, bus.busy, bus.register_A_out,
            bus.C_out}), 32'd0);
        chk("arst_b", 32'(bus.register_B_out), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_ready", 32'(bus.in_ready), 32'd1);
        run_op("post_rst", 16'h4000, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0,
               mk(16'h0030, 16'h0020, 1'b0, 1'b0, 1'b0, 1));

        for (int k = 0; k < 24; k++) begin
            op = 4'($urandom_range(3, 12));
            ra = 16'($urandom);
            rb = 16'($urandom);
            fl = 3'($urandom);
            e = model(op, ra, rb, fl[2], fl[1], fl[0]);
            run_op("rnd", {op, 12'h000}, ra, rb, fl[2], fl[1], fl[0], e);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
